// File: rtl/count_decoder.sv
// Recovers enable/direction from an observed 8-bit up/down counter and tracks lock.
// Optional feature: define COUNT_DECODER_ERRCNT_EN to keep a saturating illegal-step counter.
module count_decoder #(
    parameter int unsigned LOCK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] count_in,
    output logic       enable_out,
    output logic       dir_out,
    output logic       valid,
    output logic       wrap,
    output logic       err,
    output logic [7:0] err_count
);

    localparam int unsigned CW  = 8;
    localparam int unsigned LKW = 4;
    localparam logic [LKW-1:0] LOCK_TGT = LKW'(LOCK_CYCLES);

    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 15) begin : g_bad_lock
        $error("count_decoder: LOCK_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t         state;
    logic [LKW-1:0] lk;
    logic [CW-1:0]  prev;

    logic [CW-1:0]  step_c;
    logic [LKW-1:0] lk_next_c;
    logic           is_hold_c;
    logic           is_up_c;
    logic           is_down_c;
    logic           is_legal_c;
    logic           is_wrap_c;

    // Step classification on the modulo-256 difference between samples
    assign step_c     = CW'(count_in - prev);
    assign is_hold_c  = (step_c == 8'h00);
    assign is_up_c    = (step_c == 8'h01);
    assign is_down_c  = (step_c == 8'hFF);
    assign is_legal_c = is_hold_c | is_up_c | is_down_c;
    assign is_wrap_c  = (is_up_c && prev == 8'hFF) || (is_down_c && prev == 8'h00);
    assign lk_next_c  = lk + LKW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SYNC;
            lk         <= '0;
            prev       <= '0;
            enable_out <= 1'b0;
            dir_out    <= 1'b0;
            valid      <= 1'b0;
            wrap       <= 1'b0;
            err        <= 1'b0;
        end else begin
            prev <= count_in;
            wrap <= 1'b0;
            err  <= 1'b0;
            case (state)
                SYNC: begin
                    state <= ACQ;
                    lk    <= '0;
                end
                default: begin
                    if (!is_legal_c) begin
                        // Illegal step: drop lock, keep last recovered enable/direction
                        err   <= 1'b1;
                        state <= ACQ;
                        lk    <= '0;
                        valid <= 1'b0;
                    end else begin
                        wrap       <= is_wrap_c;
                        enable_out <= ~is_hold_c;
                        if (!is_hold_c) begin
                            dir_out <= is_up_c;
                        end
                        if (state == ACQ) begin
                            lk <= lk_next_c;
                            if (lk_next_c == LOCK_TGT) begin
                                state <= LOCKED;
                                valid <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

`ifdef COUNT_DECODER_ERRCNT_EN
    // Saturating count of illegal steps since reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (state != SYNC && !is_legal_c && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: doc/count_decoder.md
COUNT_DECODER -- requirements
Module: count_decoder

Interface
REQ-001 Parameter LOCK_CYCLES, default 2, SHALL be the number of consecutive legal steps needed to reach LOCKED; legal range 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 count_in  input  8  SHALL be the observed 8-bit up/down counter value, sampled every rising clk edge.
REQ-005 enable_out  output  1  SHALL be the recovered enable: 1 when the last step was +1 or -1, 0 when it was 0.
REQ-006 dir_out  output  1  SHALL be the recovered direction: 1 up, 0 down; holds its value through hold steps.
REQ-007 valid  output  1  SHALL be 1 only while in state LOCKED.
REQ-008 wrap  output  1  SHALL be a one-cycle pulse on a wrap-around step.
REQ-009 err  output  1  SHALL be a one-cycle pulse on an illegal step.
REQ-010 err_count  output  8  SHALL be the count of illegal steps since reset.

Function
REQ-011 The block SHALL register each sample into prev[7:0] at every edge; step = (count_in - prev) mod 256, computed in 8 bits.
REQ-012 Step classification SHALL be: 0 -> HOLD; 1 -> UP; 255 -> DOWN; any other value -> ILLEGAL.
REQ-013 Outputs SHALL be registered: after the edge that captures sample s_k, outputs reflect the s_(k-1) -> s_k step (latency 1 clk from sample to output).
REQ-014 States SHALL be SYNC, ACQ and LOCKED, with a 4-bit lock counter lk.
REQ-015 SYNC: first edge after reset; capture prev, classify nothing, go to ACQ with lk=0; no outputs change.
REQ-016 ACQ: legal step -> lk+1; when lk+1 == LOCK_CYCLES, go to LOCKED.
REQ-017 LOCKED: legal step -> stay in LOCKED.
REQ-018 ILLEGAL step in ACQ or LOCKED SHALL pulse err, go to ACQ with lk=0, keep enable_out/dir_out unchanged, and still load prev with the new sample.
REQ-019 UP SHALL set enable_out=1 and dir_out=1; DOWN SHALL set enable_out=1 and dir_out=0; HOLD SHALL set enable_out=0 and leave dir_out unchanged.
REQ-020 wrap SHALL pulse for UP with prev=8'hFF, count_in=8'h00, and for DOWN with prev=8'h00, count_in=8'hFF, in any non-SYNC state.
REQ-021 err_count SHALL increment on each err pulse and saturate at 8'hFF (no wrap).
REQ-022 A step back to 0 (counter reset) is legal only if it is a ±1 step; otherwise it counts as ILLEGAL.

Reset
REQ-023 When rst=1 at a rising edge: state=SYNC, lk=0, prev=0, enable_out=0, dir_out=0, valid=0, wrap=0, err=0, err_count=0.
REQ-024 rst SHALL take priority over all other activity, including an in-progress lock or an illegal step in the same cycle.
REQ-025 The first sample after rst deasserts SHALL be handled as SYNC (REQ-015); no err or wrap is generated for it.

Configuration
REQ-026 Macro COUNT_DECODER_ERRCNT_EN: when defined, err_count SHALL behave per REQ-021; when undefined, err_count SHALL be tied to 8'h00, the counter register SHALL be omitted, and err SHALL still pulse.

Verification
REQ-027 Reset then count_in 0,1,2,3,4 on consecutive edges -> valid=1 after the edge that samples 2, with enable_out=1 and dir_out=1 (LOCK_CYCLES=2).
REQ-028 Locked up-count 8'hFE,8'hFF,8'h00 -> wrap=1 for exactly the cycle after 8'h00 is sampled; valid stays 1.
REQ-029 Locked, then count_in 10,10,9 -> enable_out=0 with dir_out unchanged after the second 10; enable_out=1 and dir_out=0 after 9.
REQ-030 Locked at 20, then count_in 25 -> err=1 for one cycle, valid=0, err_count=1; then 26,27 -> valid=1 again.
REQ-031 Force 300 illegal steps -> err_count=8'hFF with the macro defined; err_count=8'h00 throughout with it undefined.
REQ-032 Assert rst in the same cycle as an illegal step while locked -> all outputs 0 after that edge; no err pulse.
